// File: rtl/btn_debounce_pkg.sv
// Shared types for the button debouncer: FSM state encoding and default filter length.
package btn_debounce_pkg;

    // Default qualification length: 10 ms at 100 MHz with sample_en tied high.
    localparam int unsigned DEFAULT_STABLE_CNT = 1_000_000;

    // LO/HI in the name is the debounced level held in (or leaving) that state.
    typedef enum logic [1:0] {
        StIdleLo = 2'd0,
        StWaitHi = 2'd1,
        StIdleHi = 2'd2,
        StWaitLo = 2'd3
    } state_e;

endpackage

// File: rtl/btn_debounce_if.sv
// Button-side bundle: raw pin and sample qualifier in, debounced level and busy flag out.
interface btn_debounce_if;

    logic btn_in;
    logic sample_en;
    logic db_level;
    logic busy;

    // Drives the pin and prescaler strobe, observes the filtered result.
    modport master (
        output btn_in,
        output sample_en,
        input  db_level,
        input  busy
    );

    // The debouncer itself.
    modport slave (
        input  btn_in,
        input  sample_en,
        output db_level,
        output busy
    );

endinterface

// File: rtl/btn_debounce_sync_2ff.sv
// Two-flop synchroniser with synchronous reset for asynchronous external pins.
module btn_debounce_sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_sync1;
    logic r_sync2;

    // Shift the pin through two flops every clock; reset forces both low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_d;
            r_sync2 <= r_sync1;
        end
    end

    assign o_q = r_sync2;

endmodule

// File: rtl/btn_debounce.sv
// Debouncer: synchronise the raw pin, then require STABLE_CNT consecutive qualified
// samples of a new level before the registered output follows it.
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int unsigned STABLE_CNT = DEFAULT_STABLE_CNT
) (
    input  logic          clk,
    input  logic          rst,
    btn_debounce_if.slave bus
);

    localparam int unsigned     CNT_W   = $clog2(STABLE_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT - 1);

    logic             w_sync;
    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_db_level;
    logic             r_busy;

    btn_debounce_sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (bus.btn_in),
        .o_q (w_sync)
    );

    // Qualification FSM; db_level and busy are registered alongside the state so both
    // outputs come straight from flops. The counter is cleared on every state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdleLo;
            r_cnt      <= '0;
            r_db_level <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                StIdleLo: begin
                    if (w_sync) begin
                        r_state <= StWaitHi;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                StWaitHi: begin
                    // Samples between enables are ignored, so state and count hold.
                    if (bus.sample_en) begin
                        if (!w_sync) begin
                            r_state <= StIdleLo;
                            r_cnt   <= '0;
                            r_busy  <= 1'b0;
                        end else if (r_cnt == CNT_MAX) begin
                            r_state    <= StIdleHi;
                            r_cnt      <= '0;
                            r_db_level <= 1'b1;
                            r_busy     <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                StIdleHi: begin
                    if (!w_sync) begin
                        r_state <= StWaitLo;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                StWaitLo: begin
                    if (bus.sample_en) begin
                        if (w_sync) begin
                            r_state <= StIdleHi;
                            r_cnt   <= '0;
                            r_busy  <= 1'b0;
                        end else if (r_cnt == CNT_MAX) begin
                            r_state    <= StIdleLo;
                            r_cnt      <= '0;
                            r_db_level <= 1'b0;
                            r_busy     <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state    <= StIdleLo;
                    r_cnt      <= '0;
                    r_db_level <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.db_level = r_db_level;
    assign bus.busy     = r_busy;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with STABLE_CNT=4 (6-edge qualification latency).
module tb_btn_debounce;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_vec = 0;
    int n_err = 0;

    // Activity monitor, sampled on the falling edge.
    int   busy_cnt = 0;
    int   db_hi_cnt = 0;
    int   rise_cnt = 0;
    int   fall_cnt = 0;
    logic db_prev = 1'b0;

    btn_debounce_if bus ();

    btn_debounce #(
        .STABLE_CNT (4)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Accumulate busy/level occupancy and edges of db_level as a downstream detector would.
    always @(negedge clk) begin
        busy_cnt  <= busy_cnt + int'(bus.busy);
        db_hi_cnt <= db_hi_cnt + int'(bus.db_level);
        rise_cnt  <= rise_cnt + int'(bus.db_level & ~db_prev);
        fall_cnt  <= fall_cnt + int'(~bus.db_level & db_prev);
        db_prev   <= bus.db_level;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Input has just moved to new_lvl (or sync was just cleared); expect busy after the
    // 3rd edge and db_level to follow after exactly the 7th edge (k+6).
    task automatic qualify(input string tag, input logic new_lvl);
        tick(2);
        check({tag, "_busy_k1"}, int'(bus.busy), 0);
        check({tag, "_db_k1"}, int'(bus.db_level), int'(!new_lvl));
        tick(1);
        check({tag, "_busy_k2"}, int'(bus.busy), 1);
        tick(3);
        check({tag, "_db_k5"}, int'(bus.db_level), int'(!new_lvl));
        check({tag, "_busy_k5"}, int'(bus.busy), 1);
        tick(1);
        check({tag, "_db_k6"}, int'(bus.db_level), int'(new_lvl));
        check({tag, "_busy_k6"}, int'(bus.busy), 0);
    endtask

    initial begin
        int          snap_busy;
        int          snap_hi;
        int          snap_rise;
        int          snap_fall;
        logic [5:0]  pat;

        bus.btn_in    = 1'b1;
        bus.sample_en = 1'b1;
        rst           = 1'b1;
        #1;

        // Reset held with the button pressed: outputs stay low.
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("rst_db", int'(bus.db_level), 0);
            check("rst_busy", int'(bus.busy), 0);
        end
        rst = 1'b0;
        qualify("por", 1'b1);

        // Clean release and press.
        bus.btn_in = 1'b0;
        qualify("rel", 1'b0);
        bus.btn_in = 1'b1;
        qualify("press", 1'b1);

        // Two-sample low glitch while high: busy for 2 cycles, level untouched.
        snap_busy = busy_cnt;
        snap_fall = fall_cnt;
        bus.btn_in = 1'b0;
        tick(2);
        bus.btn_in = 1'b1;
        tick(8);
        check("hglitch_busy", busy_cnt - snap_busy, 2);
        check("hglitch_fall", fall_cnt - snap_fall, 0);
        check("hglitch_db", int'(bus.db_level), 1);
        bus.btn_in = 1'b0;
        qualify("rel2", 1'b0);

        // Bounce 1,0,1,1,0,1 then held high: exactly one rise, 6 edges after last 0->1.
        snap_rise = rise_cnt;
        pat = 6'b101101;
        for (int i = 0; i < 6; i++) begin
            bus.btn_in = pat[i];
            tick(1);
            check("bnc_db_during", int'(bus.db_level), 0);
        end
        tick(5);
        check("bnc_db_j5", int'(bus.db_level), 0);
        tick(1);
        check("bnc_db_j6", int'(bus.db_level), 1);
        tick(1);
        check("bnc_pulses", rise_cnt - snap_rise, 1);
        bus.btn_in = 1'b0;
        qualify("bnc_rel", 1'b0);

        // Three-cycle high glitch: busy for 3 cycles, db_level never rises.
        snap_busy = busy_cnt;
        snap_hi   = db_hi_cnt;
        bus.btn_in = 1'b1;
        tick(3);
        bus.btn_in = 1'b0;
        tick(7);
        check("lglitch_busy", busy_cnt - snap_busy, 3);
        check("lglitch_db_hi", db_hi_cnt - snap_hi, 0);

        // sample_en every 4th clock: WAIT_HI at edge 2, enabled samples at 3,7,11,15.
        bus.btn_in = 1'b1;
        for (int i = 0; i < 15; i++) begin
            bus.sample_en = (i % 4 == 3);
            tick(1);
            if (i == 2) check("sen_busy_e2", int'(bus.busy), 1);
            if (i == 11) check("sen_db_e11", int'(bus.db_level), 0);
            if (i == 14) begin
                check("sen_db_e14", int'(bus.db_level), 0);
                check("sen_busy_e14", int'(bus.busy), 1);
            end
        end
        bus.sample_en = 1'b1;
        tick(1);
        check("sen_db_e15", int'(bus.db_level), 1);
        check("sen_busy_e15", int'(bus.busy), 0);
        bus.btn_in = 1'b0;
        qualify("sen_rel", 1'b0);

        // Reset mid-qualification (cnt=2), then a full restart with the button still high.
        bus.btn_in = 1'b1;
        tick(5);
        check("rmid_busy", int'(bus.busy), 1);
        rst = 1'b1;
        tick(1);
        check("rmid_db", int'(bus.db_level), 0);
        check("rmid_busy_clr", int'(bus.busy), 0);
        rst = 1'b0;
        qualify("rmid", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
